dm_arbiter: RTL and testbench

- Shares the single data-memory port (DM_ena/DM_W/DM_R, address, wdata, rdata) between the CPU load/store path and a DMA/debug requester.
- Uses a req/ack handshake with round-robin arbitration.
- Generates a CPU stall while a CPU access is pending.
- Sits between the CPU core, the DMA engine and the data memory in the top level.

---
 rtl/dm_arbiter_if.sv | 48 ++++
 rtl/dm_arbiter.sv | 137 +++++++++++++
 tb/tb_dm_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Bundles the CPU, DMA and data-memory signals that meet at the data-memory arbiter.
interface dm_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // CPU load/store path
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  // DMA/debug requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  // Data-memory port
  logic              mem_ena;
  logic              mem_W;
  logic              mem_R;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // System side: requesters and the memory
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_ena, mem_W, mem_R, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_ena, mem_W, mem_R, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU and a DMA/debug requester.
module dm_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   io_bus
);

  localparam int unsigned     CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_last_dma;
  logic              r_gnt_dma;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_ena;
  logic              r_mem_w;
  logic              r_mem_r;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_ack;
  logic              r_dma_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_any_req;
  logic              w_cpu_win;
  logic              w_dma_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins
  assign w_any_req   = io_bus.cpu_req | io_bus.dma_req;
  assign w_cpu_win   = io_bus.cpu_req & (~io_bus.dma_req | r_last_dma);
  assign w_dma_win   = io_bus.dma_req & ~w_cpu_win;
  assign w_sel_we    = w_dma_win ? io_bus.dma_we    : io_bus.cpu_we;
  assign w_sel_addr  = w_dma_win ? io_bus.dma_addr  : io_bus.cpu_addr;
  assign w_sel_wdata = w_dma_win ? io_bus.dma_wdata : io_bus.cpu_wdata;

  // Access sequencer: grant, drive the memory port, wait out read latency, pulse ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last_dma  <= 1'b1;
      r_gnt_dma   <= 1'b0;
      r_cnt       <= '0;
      r_mem_ena   <= 1'b0;
      r_mem_w     <= 1'b0;
      r_mem_r     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_dma   <= w_dma_win;
            r_last_dma  <= w_dma_win;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_ena   <= 1'b1;
            r_mem_w     <= w_sel_we;
            r_mem_r     <= ~w_sel_we;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_mem_w || RD_LAT == 1) begin
            // A write, or a single-cycle read whose data is valid at this edge
            if (!r_mem_w) begin
              if (r_gnt_dma) r_dma_rdata <= io_bus.mem_rdata;
              else           r_cpu_rdata <= io_bus.mem_rdata;
            end
            r_cpu_ack <= ~r_gnt_dma;
            r_dma_ack <= r_gnt_dma;
            r_mem_ena <= 1'b0;
            r_mem_w   <= 1'b0;
            r_mem_r   <= 1'b0;
            r_state   <= S_ACK;
          end else begin
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_gnt_dma) r_dma_rdata <= io_bus.mem_rdata;
            else           r_cpu_rdata <= io_bus.mem_rdata;
            r_cpu_ack <= ~r_gnt_dma;
            r_dma_ack <= r_gnt_dma;
            r_mem_ena <= 1'b0;
            r_mem_r   <= 1'b0;
            r_state   <= S_ACK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.mem_ena   = r_mem_ena;
  assign io_bus.mem_W     = r_mem_w;
  assign io_bus.mem_R     = r_mem_r;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.cpu_ack   = r_cpu_ack;
  assign io_bus.dma_ack   = r_dma_ack;
  assign io_bus.cpu_rdata = r_cpu_rdata;
  assign io_bus.dma_rdata = r_dma_rdata;

  // The CPU stalls as long as its request is outstanding and not yet acknowledged
  assign io_bus.cpu_stall = io_bus.cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboarded bench for dm_arbiter: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_dm_arbiter;

  typedef struct {
    bit          dma;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q1[$];
  exp_t q3[$];
  exp_t m1;
  exp_t m3;

  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  int          rc1;
  int          rc3;

  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (b1.slave)
  );

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (b3.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: data is presented only in the RD_LAT-th cycle of a read, garbage otherwise
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= 32'hA500_0000 | 32'(i);
        mem3[i] <= 32'hA500_0000 | 32'(i);
      end
      mem3[8] <= 32'h1234_5678;
      rc1 <= 0;
      rc3 <= 0;
    end else begin
      if (b1.mem_ena && b1.mem_W) mem1[b1.mem_addr[5:2]] <= b1.mem_wdata;
      if (b3.mem_ena && b3.mem_W) mem3[b3.mem_addr[5:2]] <= b3.mem_wdata;
      rc1 <= b1.mem_R ? rc1 + 1 : 0;
      rc3 <= b3.mem_R ? rc3 + 1 : 0;
    end
  end

  assign b1.mem_rdata = (b1.mem_R && rc1 == 0) ? mem1[b1.mem_addr[5:2]] : 32'hBADB_AD00;
  assign b3.mem_rdata = (b3.mem_R && rc3 == 2) ? mem3[b3.mem_addr[5:2]] : 32'hBADB_AD00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the RD_LAT=1 instance
  always @(negedge clk) begin
    if (rst && (b1.cpu_ack || b1.dma_ack)) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut1_unexpected_ack: cpu_ack=%0b dma_ack=%0b at cycle %0d, none expected",
                 b1.cpu_ack, b1.dma_ack, cyc);
      end else begin
        m1 = q1.pop_front();
        chk("dut1_ack_who", {30'b0, b1.dma_ack, b1.cpu_ack}, m1.dma ? 32'd2 : 32'd1);
        chk("dut1_ack_cycle", cyc, m1.cyc);
        if (m1.rd) chk("dut1_rdata", m1.dma ? b1.dma_rdata : b1.cpu_rdata, m1.data);
      end
    end
  end

  // Monitor for the RD_LAT=3 instance
  always @(negedge clk) begin
    if (rst && (b3.cpu_ack || b3.dma_ack)) begin
      if (q3.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut3_unexpected_ack: cpu_ack=%0b dma_ack=%0b at cycle %0d, none expected",
                 b3.cpu_ack, b3.dma_ack, cyc);
      end else begin
        m3 = q3.pop_front();
        chk("dut3_ack_who", {30'b0, b3.dma_ack, b3.cpu_ack}, m3.dma ? 32'd2 : 32'd1);
        chk("dut3_ack_cycle", cyc, m3.cyc);
        if (m3.rd) chk("dut3_rdata", m3.dma ? b3.dma_rdata : b3.cpu_rdata, m3.data);
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int seen;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = '0; b1.dma_wdata = '0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.dma_req = 0; b3.dma_we = 0; b3.dma_addr = '0; b3.dma_wdata = '0;
    repeat (3) next();
    @(negedge clk);
    chk("reset_mem_ena", b3.mem_ena, 0);
    chk("reset_acks", {30'b0, b3.dma_ack, b3.cpu_ack}, 0);
    next();
    rst = 1'b1;
    next();

    // CPU store on the RD_LAT=1 instance
    c0 = cyc;
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 32'h10; b1.cpu_wdata = 32'hDEAD_BEEF;
    q1.push_back('{dma: 1'b0, rd: 1'b0, data: 32'h0, cyc: c0 + 2});
    @(negedge clk);
    chk("t1_stall_c0", b1.cpu_stall, 1);
    next(); @(negedge clk);
    chk("t1_mem_W_c1", b1.mem_W, 1);
    chk("t1_mem_addr_c1", b1.mem_addr, 32'h10);
    chk("t1_mem_wdata_c1", b1.mem_wdata, 32'hDEAD_BEEF);
    chk("t1_stall_c1", b1.cpu_stall, 1);
    next(); @(negedge clk);
    chk("t1_cpu_ack_c2", b1.cpu_ack, 1);
    chk("t1_stall_c2", b1.cpu_stall, 0);
    next();
    b1.cpu_req = 0;
    next();

    // CPU load on the RD_LAT=1 instance: ack in cycle 2
    c0 = cyc;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h14;
    q1.push_back('{dma: 1'b0, rd: 1'b1, data: 32'hA500_0005, cyc: c0 + 2});
    repeat (3) next();
    b1.cpu_req = 0;
    next();
    chk("t1_mem_stored", mem1[4], 32'hDEAD_BEEF);

    // DMA read on the RD_LAT=3 instance
    c0 = cyc;
    b3.dma_req = 1; b3.dma_we = 0; b3.dma_addr = 32'h20;
    q3.push_back('{dma: 1'b1, rd: 1'b1, data: 32'h1234_5678, cyc: c0 + 4});
    for (int k = 1; k <= 3; k++) begin
      next(); @(negedge clk);
      chk("t2_mem_R_held", b3.mem_R, 1);
      chk("t2_mem_addr_held", b3.mem_addr, 32'h20);
    end
    next();
    next();
    b3.dma_req = 0;
    next();

    // Both requesters held: grants alternate CPU, DMA, CPU, DMA
    c0 = cyc;
    b3.cpu_req = 1; b3.cpu_we = 1; b3.cpu_addr = 32'h04; b3.cpu_wdata = 32'h1111_1111;
    b3.dma_req = 1; b3.dma_we = 1; b3.dma_addr = 32'h0C; b3.dma_wdata = 32'h2222_2222;
    q3.push_back('{dma: 1'b0, rd: 1'b0, data: 32'h0, cyc: c0 + 2});
    q3.push_back('{dma: 1'b1, rd: 1'b0, data: 32'h0, cyc: c0 + 5});
    q3.push_back('{dma: 1'b0, rd: 1'b0, data: 32'h0, cyc: c0 + 8});
    q3.push_back('{dma: 1'b1, rd: 1'b0, data: 32'h0, cyc: c0 + 11});
    repeat (10) next();
    b3.cpu_req = 0;
    b3.dma_req = 0;
    repeat (3) next();
    chk("t3_cpu_write", mem3[1], 32'h1111_1111);
    chk("t3_dma_write", mem3[3], 32'h2222_2222);
    chk("t3_rdata_kept", b3.dma_rdata, 32'h1234_5678);

    // Reset during WAIT of a CPU read discards the access
    c0 = cyc;
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 32'h08;
    next();
    next();
    #1;
    rst = 1'b0;
    b3.cpu_req = 0;
    #1;
    chk("t4_mem_ena", b3.mem_ena, 0);
    chk("t4_mem_R", b3.mem_R, 0);
    chk("t4_mem_addr", b3.mem_addr, 0);
    chk("t4_cpu_ack", b3.cpu_ack, 0);
    chk("t4_dma_rdata", b3.dma_rdata, 0);
    repeat (3) next();
    rst = 1'b1;
    next();
    @(negedge clk);
    chk("t4_no_ack_after_reset", b3.cpu_ack, 0);
    next();
    c0 = cyc;
    b3.cpu_req = 1; b3.cpu_we = 1; b3.cpu_addr = 32'h18; b3.cpu_wdata = 32'h3333_3333;
    b3.dma_req = 1; b3.dma_we = 1; b3.dma_addr = 32'h1C; b3.dma_wdata = 32'h4444_4444;
    q3.push_back('{dma: 1'b0, rd: 1'b0, data: 32'h0, cyc: c0 + 2});
    q3.push_back('{dma: 1'b1, rd: 1'b0, data: 32'h0, cyc: c0 + 5});
    repeat (3) next();
    b3.cpu_req = 0;
    repeat (3) next();
    b3.dma_req = 0;
    next();

    // CPU drops req and scrambles its bus right after grant; the store still completes
    c0 = cyc;
    b3.cpu_req = 1; b3.cpu_we = 1; b3.cpu_addr = 32'h30; b3.cpu_wdata = 32'hCAFE_F00D;
    q3.push_back('{dma: 1'b0, rd: 1'b0, data: 32'h0, cyc: c0 + 2});
    next();
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 32'h34; b3.cpu_wdata = 32'h0BAD_F00D;
    seen = 0;
    repeat (6) begin
      next(); @(negedge clk);
      if (cyc >= c0 + 3 && b3.mem_ena) seen++;
    end
    chk("t5_no_extra_access", 32'(seen), 0);
    chk("t5_store_written", mem3[12], 32'hCAFE_F00D);
    chk("t5_other_untouched", mem3[13], 32'hA500_000D);

    chk("scoreboard_drained", 32'(q1.size() + q3.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
